mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide controller for the five-stage MIPS pipeline. It sits beside the execute-stage ALU and owns the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and models fixed multiply and divide latencies with a countdown counter. It raises a stall request while busy so that dependent HI/LO instructions are held in E, and it supplies HI or LO to the E-stage result mux for mfhi/mflo.

## Interface
Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op_e  input  6  E-stage opcode
- funct_e  input  6  E-stage funct field
- valid_e  input  1  E-stage instruction valid (not bubble or flushed)
- a_e  input  32  rs operand (forwarded)
- b_e  input  32  rt operand (forwarded)
- busy  output  1  unit is computing (state BUSY)
- stall_req  output  1  hold F/D/E and bubble M this cycle
- mdu_out  output  32  HI for mfhi, LO for mflo, else 0
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- The unit recognises an MDU op when valid_e=1, op_e=6'b000000, and funct_e is one of: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Any other op_e or funct_e is ignored and never stalls.
- The controller has two states, IDLE and BUSY, plus a 4-bit counter cnt.
- IDLE, start op (mult/multu/div/divu) present:
  - On the clock edge, latch the operands and the op kind and load cnt with MUL_CYCLES or DIV_CYCLES.
  - Go to BUSY. No stall is raised for the start op itself.
- IDLE, mthi/mtlo present: hi or lo is loaded with a_e at the clock edge. State stays IDLE.
- IDLE, mfhi/mflo present: mdu_out shows hi or lo combinationally. No stall.
- BUSY, every cycle: cnt decrements.
- BUSY, cnt==1 at the clock edge:
  - Write the results to hi/lo.
  - Go to IDLE with cnt=0.
- BUSY, any MDU op present in E: stall_req=1 and the op is not executed. A non-MDU op in E proceeds with stall_req=0.
- stall_req is combinational: (state==BUSY) && MDU op present.
- Result arithmetic, computed on the latched operands:
  - mult: {hi,lo} is the signed 64-bit product.
  - multu: {hi,lo} is the unsigned 64-bit product.
  - div/divu: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend (signed or unsigned per op).
- Divide by zero: lo=32'hFFFFFFFF, hi=dividend.
- Signed overflow (div 0x80000000 by 0xFFFFFFFF): lo=32'h80000000, hi=0.
- Operands are captured at the start edge. Later changes to a_e/b_e have no effect on the result.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, hi=0, lo=0, busy=0, stall_req=0, mdu_out=0.
- Reset asserted mid-operation aborts the operation. HI/LO clear to 0 and no result is written.
- The start op is sampled at edge t. busy=1 for cycles t+1 through t+N (N = MUL_CYCLES or DIV_CYCLES).
- hi/lo update at the edge ending cycle t+N. busy=0 in cycle t+N+1.
- The first cycle a dependent mfhi/mflo can complete is t+N+1, and it reads the new value.
- Completion edge with an MDU op in E during cycle t+N: that op stalls in cycle t+N and executes in t+N+1. The unit never starts an op on the same edge it completes.
- Back-to-back start ops: the second one stalls until IDLE, then starts.
- mthi/mtlo issued while BUSY stall and do not corrupt the in-flight result.

## Test plan
- Reset, then mult a=0xFFFFFFFE (-2), b=3 at edge 0:
  - busy high for cycles 1–5, stall_req=0 with no MDU op in E.
  - At cycle 6, hi=0xFFFFFFFF and lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2, with mflo held in E from cycle 1:
  - stall_req=1 for cycles 1–5.
  - Cycle 6: mdu_out=lo=0xFFFFFFFE, hi=1.
- div a=-7 (0xFFFFFFF9), b=2: busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu with the same operands: lo=0x7FFFFFFC, hi=1.
- div by zero with a=0x12345678: lo=0xFFFFFFFF, hi=0x12345678. div 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi 0xAA in IDLE → hi=0xAA next cycle, no stall. Then mult 3×4 immediately followed by mtlo 0x55:
  - mtlo stalls until the mult completes (lo=12, hi=0).
  - mtlo then executes, giving lo=0x55.
- Start div, then pull rst_n low at cycle 4:
  - All outputs go to 0 immediately.
  - After release, busy stays 0 and hi/lo stay 0 with no late write.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the E stage: owns HI/LO, models fixed
// mult/div latency with a down-counter and requests a pipeline stall while busy.
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op_e,
  input  logic [5:0]  funct_e,
  input  logic        valid_e,
  input  logic [31:0] a_e,
  input  logic [31:0] b_e,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  // state  | meaning
  // IDLE   | accepts start ops, mthi/mtlo writes, mfhi/mflo reads
  // BUSY   | counting down the op latency; every MDU op in E stalls

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [1:0]  r_kind;

  logic        w_is_r, w_start_op, w_mdu_op, w_start, w_done;
  logic        w_ovf, w_bzero;
  logic [63:0] w_prod_s, w_prod_u;
  logic signed [31:0] w_sa, w_sb_safe, w_q_s, w_r_s;
  logic [31:0] w_ub_safe, w_q_u, w_r_u;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_is_r     = valid_e && (op_e == 6'b000000);
  assign w_start_op = w_is_r && (funct_e == F_MULT || funct_e == F_MULTU ||
                                 funct_e == F_DIV  || funct_e == F_DIVU);
  assign w_mdu_op   = w_start_op || (w_is_r && (funct_e == F_MFHI || funct_e == F_MTHI ||
                                                funct_e == F_MFLO || funct_e == F_MTLO));
  assign w_start    = (r_state == S_IDLE) && w_start_op;
  assign w_done     = (r_state == S_BUSY) && (r_cnt == 4'd1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_BUSY;
      S_BUSY: if (w_done)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Divisor is forced to 1 on the special cases so the divider never sees x/0 or
  // the one overflowing quotient; those results come from the fixed-value mux below.
  assign w_bzero   = (r_b == 32'd0);
  assign w_ovf     = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_sa      = $signed(r_a);
  assign w_sb_safe = (w_bzero || w_ovf) ? 32'sd1 : $signed(r_b);
  assign w_ub_safe = w_bzero ? 32'd1 : r_b;
  assign w_q_s     = w_sa / w_sb_safe;
  assign w_r_s     = w_sa % w_sb_safe;
  assign w_q_u     = r_a / w_ub_safe;
  assign w_r_u     = r_a % w_ub_safe;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (r_kind)
      2'b00: {w_res_hi, w_res_lo} = w_prod_s;
      2'b01: {w_res_hi, w_res_lo} = w_prod_u;
      2'b10: begin
        if (w_bzero) begin
          w_res_hi = r_a;
          w_res_lo = 32'hFFFF_FFFF;
        end else if (w_ovf) begin
          w_res_hi = 32'd0;
          w_res_lo = 32'h8000_0000;
        end else begin
          w_res_hi = w_r_s;
          w_res_lo = w_q_s;
        end
      end
      default: begin
        if (w_bzero) begin
          w_res_hi = r_a;
          w_res_lo = 32'hFFFF_FFFF;
        end else begin
          w_res_hi = w_r_u;
          w_res_lo = w_q_u;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_kind  <= 2'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_done) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end else if (w_start) begin
        r_a    <= a_e;
        r_b    <= b_e;
        r_kind <= funct_e[1:0];
        r_cnt  <= funct_e[1] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
      end else if (w_is_r && funct_e == F_MTHI) begin
        r_hi <= a_e;
      end else if (w_is_r && funct_e == F_MTLO) begin
        r_lo <= a_e;
      end
    end
  end

  assign busy      = (r_state == S_BUSY);
  assign stall_req = (r_state == S_BUSY) && w_mdu_op;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign mdu_out   = (w_is_r && funct_e == F_MFHI) ? r_hi :
                     (w_is_r && funct_e == F_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: drives E-stage ops cycle by cycle and checks
// busy/stall/HI/LO/mdu_out against hand-computed values.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op_e, funct_e;
  logic        valid_e;
  logic [31:0] a_e, b_e;
  logic        busy, stall_req;
  logic [31:0] mdu_out, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .op_e(op_e), .funct_e(funct_e), .valid_e(valid_e),
    .a_e(a_e), .b_e(b_e), .busy(busy), .stall_req(stall_req), .mdu_out(mdu_out),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid_e = 1'b1; op_e = 6'd0; funct_e = f; a_e = a; b_e = b;
  endtask

  task automatic idle_in();
    valid_e = 1'b0; op_e = 6'd0; funct_e = 6'd0; a_e = 32'hDEAD_BEEF; b_e = 32'h0BAD_F00D;
  endtask

  // Start op in the current cycle, then check busy for n cycles and idle after.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    set_op(f, a, b);
    mid();
    chk({tag, "_nostall_start"}, {31'd0, stall_req}, 32'd0);
    next_cycle();
    idle_in();
    for (int i = 1; i <= n; i++) begin
      mid();
      chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, busy}, 32'd1);
      next_cycle();
    end
    mid();
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mdu_out", mdu_out, 32'd0);
    mid();
    rst_n = 1'b1;
    next_cycle();

    // mult -2 * 3, no MDU op in E while busy
    set_op(F_MULT, 32'hFFFF_FFFE, 32'd3);
    next_cycle();
    idle_in();
    for (int i = 1; i <= 5; i++) begin
      mid();
      chk($sformatf("mult_busy_c%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("mult_nostall_c%0d", i), {31'd0, stall_req}, 32'd0);
      next_cycle();
    end
    mid();
    chk("mult_busy_c6", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    next_cycle();

    // multu with dependent mflo held in E
    set_op(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    next_cycle();
    set_op(F_MFLO, 32'd0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      mid();
      chk($sformatf("multu_stall_c%0d", i), {31'd0, stall_req}, 32'd1);
      next_cycle();
    end
    mid();
    chk("multu_stall_c6", {31'd0, stall_req}, 32'd0);
    chk("multu_mdu_out", mdu_out, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    chk("multu_hi", hi, 32'd1);
    next_cycle();
    idle_in();

    run_op("div", F_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    next_cycle();
    run_op("divu", F_DIVU, 32'hFFFF_FFF9, 32'd2, 10);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'd1);
    next_cycle();
    run_op("div0", F_DIV, 32'h1234_5678, 32'd0, 10);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'h1234_5678);
    next_cycle();
    set_op(F_MFHI, 32'd0, 32'd0);
    mid();
    chk("mfhi_idle_out", mdu_out, 32'h1234_5678);
    chk("mfhi_idle_nostall", {31'd0, stall_req}, 32'd0);
    next_cycle();
    idle_in();
    run_op("divovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);
    next_cycle();

    // mthi in IDLE
    set_op(F_MTHI, 32'h0000_00AA, 32'd0);
    mid();
    chk("mthi_nostall", {31'd0, stall_req}, 32'd0);
    next_cycle();
    idle_in();
    mid();
    chk("mthi_hi", hi, 32'h0000_00AA);
    next_cycle();

    // mult 3x4 then mtlo 0x55 stalls until completion
    set_op(F_MULT, 32'd3, 32'd4);
    next_cycle();
    set_op(F_MTLO, 32'h0000_0055, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      mid();
      chk($sformatf("mtlo_stall_c%0d", i), {31'd0, stall_req}, 32'd1);
      next_cycle();
    end
    mid();
    chk("mult34_lo", lo, 32'd12);
    chk("mult34_hi", hi, 32'd0);
    chk("mtlo_nostall_c6", {31'd0, stall_req}, 32'd0);
    next_cycle();
    idle_in();
    mid();
    chk("mtlo_lo", lo, 32'h0000_0055);
    chk("mtlo_hi_kept", hi, 32'd0);
    next_cycle();

    // reset aborts an in-flight div
    set_op(F_DIV, 32'd100, 32'd7);
    next_cycle();
    set_op(F_MFLO, 32'd0, 32'd0);
    for (int i = 1; i <= 3; i++) next_cycle();
    mid();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_stall", {31'd0, stall_req}, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_mdu_out", mdu_out, 32'd0);
    idle_in();
    mid();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      mid();
      chk($sformatf("post_rst_busy_%0d", i), {31'd0, busy}, 32'd0);
    end
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
